// File: rtl/pq_sort_controller.sv
// pq_sort_controller
//   Batch sorter front-end for the register-tree priority queue. Keys arrive
//   on a valid/ready input stream and are pushed into the queue one at a time
//   with o_pq_wrt. Once the batch closes, the queue is drained with o_pq_read,
//   and the keys leave in queue-priority order on a valid/ready output stream.
//   After every strobe the controller waits SETTLE_CYCLES idle cycles so the
//   queue's compare-and-swap passes can settle. Only then does it issue the
//   next strobe or sample i_pq_data.
//
//   Optional feature macro: PQ_SORT_CTRL_STATS_EN
//     When defined, this adds o_batch_count (completed batches, wraps) and
//     o_stall_cycles (output backpressure cycles, saturates).
//
//   Handshake semantics, used on both streams:
//     A beat transfers on a rising CLK edge where valid && ready are both high.
//     While valid is high, the source holds its data and valid stable until the
//     transfer. valid never depends on ready in the same cycle.
//
//   A batch closes on the accepted beat that carries i_last, on reaching
//   QUEUE_SIZE keys, or when the queue reports full.

module pq_sort_controller #(
    parameter int QUEUE_SIZE    = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_pq_wrt,
    output logic                  o_pq_read,
    output logic [DATA_WIDTH-1:0] o_pq_data,
    input  logic                  i_pq_full,
    input  logic                  i_pq_empty,
    input  logic [DATA_WIDTH-1:0] i_pq_data,
    output logic [2:0]            o_dbg_state
`ifdef PQ_SORT_CTRL_STATS_EN
    ,
    output logic [15:0]           o_batch_count,
    output logic [31:0]           o_stall_cycles
`endif
);

    localparam int CW = $clog2(QUEUE_SIZE + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        FILL_ACCEPT   = 3'd0,
        FILL_SETTLE   = 3'd1,
        DRAIN_SAMPLE  = 3'd2,
        DRAIN_PRESENT = 3'd3,
        DRAIN_SETTLE  = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] count;       // keys currently held by the queue
    logic [SW-1:0] settle_cnt;  // remaining idle cycles after the last strobe
    logic          batch_last;  // the most recently accepted beat closed the batch
    logic          err_flag;    // queue reported empty while keys were expected

    assign o_dbg_state = state;

    // Main controller FSM. Every output is registered here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= FILL_ACCEPT;
            count      <= '0;
            settle_cnt <= '0;
            batch_last <= 1'b0;
            err_flag   <= 1'b0;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_data     <= '0;
            o_pq_wrt   <= 1'b0;
            o_pq_read  <= 1'b0;
            o_pq_data  <= '0;
        end else begin
            // Strobes are single-cycle pulses by default.
            o_pq_wrt  <= 1'b0;
            o_pq_read <= 1'b0;
            case (state)
                FILL_ACCEPT: begin
                    if (i_valid && o_ready) begin
                        o_pq_wrt   <= 1'b1;
                        o_pq_data  <= i_data;
                        count      <= count + CW'(1);
                        o_ready    <= 1'b0;
                        batch_last <= i_last;
                        settle_cnt <= SW'(SETTLE_CYCLES);
                        state      <= FILL_SETTLE;
                    end
                end
                FILL_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end else if (batch_last || (count == CW'(QUEUE_SIZE)) || i_pq_full) begin
                        state <= DRAIN_SAMPLE;
                    end else begin
                        o_ready <= 1'b1;
                        state   <= FILL_ACCEPT;
                    end
                end
                DRAIN_SAMPLE: begin
                    o_data  <= i_pq_data;
                    o_valid <= 1'b1;
                    state   <= DRAIN_PRESENT;
                    if (i_pq_empty && (count != '0)) begin
                        // The queue lost track of keys: end the batch here.
                        o_last   <= 1'b1;
                        count    <= '0;
                        err_flag <= 1'b1;
                    end else begin
                        o_last <= (count == CW'(1));
                    end
                end
                DRAIN_PRESENT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        if (err_flag) begin
                            err_flag <= 1'b0;
                            o_ready  <= 1'b1;
                            state    <= FILL_ACCEPT;
                        end else begin
                            o_pq_read  <= 1'b1;
                            count      <= count - CW'(1);
                            settle_cnt <= SW'(SETTLE_CYCLES);
                            state      <= DRAIN_SETTLE;
                        end
                    end
                end
                DRAIN_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end else if (count != '0) begin
                        state <= DRAIN_SAMPLE;
                    end else begin
                        o_ready <= 1'b1;
                        state   <= FILL_ACCEPT;
                    end
                end
                default: begin
                    o_ready <= 1'b1;
                    state   <= FILL_ACCEPT;
                end
            endcase
        end
    end

`ifdef PQ_SORT_CTRL_STATS_EN
    // Batch completion counter (wraps) and output stall counter (saturates).
    always_ff @(posedge CLK) begin
        if (RST) begin
            o_batch_count  <= '0;
            o_stall_cycles <= '0;
        end else begin
            if ((state == DRAIN_PRESENT) && i_ready && o_last)
                o_batch_count <= o_batch_count + 16'd1;
            if ((state == DRAIN_PRESENT) && !i_ready && (o_stall_cycles != '1))
                o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pq_sort_controller.sv
// tb_pq_sort_controller
//   Bench for pq_sort_controller. It contains a behavioural max-first priority
//   queue peripheral, a batch reference model (sort each closed batch in
//   descending order), and output, strobe and backpressure monitors.
//   The optional stats ports are checked when PQ_SORT_CTRL_STATS_EN is defined.

module tb_pq_sort_controller;

    localparam int QS = 8;
    localparam int DW = 16;
    localparam int SC = 8;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [DW-1:0] i_data = '0;
    logic          i_last = 1'b0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_last;
    logic          o_pq_wrt;
    logic          o_pq_read;
    logic [DW-1:0] o_pq_data;
    logic          i_pq_full;
    logic          i_pq_empty;
    logic [DW-1:0] i_pq_data;
    logic [2:0]    o_dbg_state;
`ifdef PQ_SORT_CTRL_STATS_EN
    logic [15:0]   o_batch_count;
    logic [31:0]   o_stall_cycles;
`endif

    pq_sort_controller #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .SETTLE_CYCLES(SC)) dut (
        .CLK(CLK), .RST(RST),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_last(i_last),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
        .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
        .i_pq_full(i_pq_full), .i_pq_empty(i_pq_empty), .i_pq_data(i_pq_data),
        .o_dbg_state(o_dbg_state)
`ifdef PQ_SORT_CTRL_STATS_EN
        , .o_batch_count(o_batch_count), .o_stall_cycles(o_stall_cycles)
`endif
    );

    // ---------------- check task ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- queue peripheral model (max-first) ----------------
    logic [DW-1:0] pq_mem[$];
    logic          pq_clear    = 1'b0;
    logic          force_empty = 1'b0;
    logic          pq_empty_r  = 1'b1;
    logic          pq_full_r   = 1'b0;
    logic [DW-1:0] pq_top_r    = '0;

    assign i_pq_data  = pq_top_r;
    assign i_pq_full  = pq_full_r;
    assign i_pq_empty = pq_empty_r | force_empty;

    function automatic int max_idx();
        int mi = 0;
        for (int i = 1; i < pq_mem.size(); i++)
            if (pq_mem[i] > pq_mem[mi]) mi = i;
        return mi;
    endfunction

    always @(posedge CLK) begin
        if (RST || pq_clear) pq_mem.delete();
        else if (o_pq_wrt) pq_mem.push_back(o_pq_data);
        else if (o_pq_read && pq_mem.size() > 0) pq_mem.delete(max_idx());
        pq_top_r   <= (pq_mem.size() > 0) ? pq_mem[max_idx()] : '0;
        pq_full_r  <= (pq_mem.size() >= QS);
        pq_empty_r <= (pq_mem.size() == 0);
    end

    // ---------------- downstream ready driver ----------------
    logic hold_low   = 1'b0;
    logic rand_ready = 1'b0;
    always @(posedge CLK) begin
        #1;
        if (hold_low) i_ready = 1'b0;
        else if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
        else i_ready = 1'b1;
    end

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] batch_q[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];

    task automatic flush_batch();
        batch_q.rsort();
        for (int i = 0; i < batch_q.size(); i++) begin
            exp_q.push_back(batch_q[i]);
            exp_last_q.push_back(i == batch_q.size() - 1);
        end
        batch_q.delete();
    endtask

    // ---------------- output / strobe monitor ----------------
    int            cyc = 0;
    int            last_strobe_cyc = -100;
    logic          prev_strobe = 1'b0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    int            exp_batches = 0;
    int            exp_stalls = 0;

    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            prev_hold       = 1'b0;
            prev_strobe     = 1'b0;
            last_strobe_cyc = -100;
            exp_batches     = 0;
            exp_stalls      = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", o_valid, 1);
                check("hold_data", o_data, prev_data);
                check("hold_last", o_last, prev_last);
                check("hold_no_read", o_pq_read, 0);
            end
            if (o_pq_wrt || o_pq_read) begin
                check("strobe_excl", o_pq_wrt && o_pq_read, 0);
                check("strobe_width", prev_strobe, 0);
                check("strobe_gap", (cyc - last_strobe_cyc) >= SC + 1, 1);
                last_strobe_cyc = cyc;
            end
            prev_strobe = o_pq_wrt || o_pq_read;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 1, 0);
                end else begin
                    check("out_data", o_data, exp_q.pop_front());
                    check("out_last", o_last, exp_last_q.pop_front());
                end
                if (o_last) exp_batches++;
            end
            if (o_valid && !i_ready) exp_stalls++;
            prev_hold = o_valid && !i_ready;
            prev_data = o_data;
            prev_last = o_last;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_key(input logic [DW-1:0] d, input logic l, input bit rec);
        int t = 0;
        @(posedge CLK); #1;
        i_valid = 1'b1; i_data = d; i_last = l;
        while (t < 3000) begin
            @(negedge CLK);
            if (o_ready) break;
            t++;
        end
        if (t >= 3000) begin
            check("send_timeout", 0, 1);
        end else begin
            @(posedge CLK); #1;
            if (rec) begin
                batch_q.push_back(d);
                if (l || batch_q.size() == QS) flush_batch();
            end
        end
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (t < 3000) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && o_ready) break;
            t++;
        end
        if (t >= 3000) check("drain_timeout", 0, 1);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge CLK); #1;
        RST = 1'b1;
        exp_q.delete(); exp_last_q.delete(); batch_q.delete();
        repeat (cycles) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        int rd_seen;
        int n;

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_data", o_data, 0);
        check("rst_wrt", o_pq_wrt, 0);
        check("rst_read", o_pq_read, 0);
        check("rst_pq_data", o_pq_data, 0);

        // Basic batch, downstream always ready.
        send_key(16'd5, 1'b0, 1'b1);
        send_key(16'd3, 1'b0, 1'b1);
        send_key(16'd9, 1'b0, 1'b1);
        send_key(16'd1, 1'b1, 1'b1);
        wait_drain();
        check("basic_ready_after", o_ready, 1);

        // Backpressure during presentation.
        hold_low = 1'b1;
        send_key(16'd40, 1'b0, 1'b1);
        send_key(16'd70, 1'b1, 1'b1);
        t = 0;
        while (t < 200 && !o_valid) begin @(negedge CLK); t++; end
        check("bp_valid_seen", o_valid, 1);
        rd_seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (o_pq_read) rd_seen++;
        end
        check("bp_valid_held", o_valid, 1);
        check("bp_no_read", rd_seen, 0);
        hold_low = 1'b0;
        wait_drain();

        // Overflow guard: ten keys without i_last.
        for (int k = 1; k <= 8; k++) send_key(DW'(k), 1'b0, 1'b1);
        send_key(16'd9, 1'b0, 1'b1);
        check("ovf_first_batch_done", exp_q.size(), 0);
        send_key(16'd10, 1'b0, 1'b1);
        send_key(16'd0, 1'b1, 1'b1);
        wait_drain();

        // Queue reports empty while keys are still expected.
        force_empty = 1'b1;
        send_key(16'd3, 1'b0, 1'b0);
        send_key(16'd7, 1'b1, 1'b0);
        exp_q.push_back(16'd7);
        exp_last_q.push_back(1'b1);
        wait_drain();
        check("err_ready", o_ready, 1);
        force_empty = 1'b0;
        @(posedge CLK); #1 pq_clear = 1'b1;
        @(posedge CLK); #1 pq_clear = 1'b0;

        // Randomized batches with random downstream readiness.
        rand_ready = 1'b1;
        for (int b = 0; b < 10; b++) begin
            n = $urandom_range(1, QS);
            for (int k = 0; k < n; k++)
                send_key(DW'($urandom), (k == n - 1) && (n < QS || $urandom_range(0, 1) == 1), 1'b1);
            wait_drain();
        end
        rand_ready = 1'b0;

`ifdef PQ_SORT_CTRL_STATS_EN
        @(negedge CLK);
        check("stats_batches", o_batch_count, exp_batches);
        check("stats_stalls", o_stall_cycles, exp_stalls);
`endif

        // Reset in the middle of a drain, then a fresh single-key batch.
        send_key(16'd4, 1'b0, 1'b1);
        send_key(16'd8, 1'b0, 1'b1);
        send_key(16'd2, 1'b0, 1'b1);
        send_key(16'd6, 1'b1, 1'b1);
        t = 0;
        while (t < 500 && exp_q.size() > 2) begin @(negedge CLK); t++; end
        check("mid_two_popped", exp_q.size(), 2);
        do_reset(2);
        @(negedge CLK);
        check("mid_rst_ready", o_ready, 1);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_last", o_last, 0);
        check("mid_rst_data", o_data, 0);
        check("mid_rst_wrt", o_pq_wrt, 0);
        check("mid_rst_read", o_pq_read, 0);
        check("mid_rst_pq_data", o_pq_data, 0);
`ifdef PQ_SORT_CTRL_STATS_EN
        check("mid_rst_batches", o_batch_count, 0);
        check("mid_rst_stalls", o_stall_cycles, 0);
`endif
        send_key(16'd7, 1'b1, 1'b1);
        wait_drain();

`ifdef PQ_SORT_CTRL_STATS_EN
        // Two batches, downstream held low for three cycles once.
        do_reset(2);
        send_key(16'd11, 1'b1, 1'b1);
        wait_drain();
        hold_low = 1'b1;
        send_key(16'd12, 1'b1, 1'b1);
        t = 0;
        while (t < 200 && !o_valid) begin @(negedge CLK); t++; end
        @(posedge CLK); @(posedge CLK); @(posedge CLK);
        #1 hold_low = 1'b0;
        wait_drain();
        @(negedge CLK);
        check("stats2_batches", o_batch_count, 2);
        check("stats2_stalls", o_stall_cycles, exp_stalls);
`endif

        check("final_exp_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
